// File: rtl/wave_ram_loader.sv
// Writer side of the DDS ping-pong waveform table: streams DEPTH samples into the inactive bank, then flips rd_bank.
// Optional feature macro: WAVE_LOADER_CHECKSUM_EN adds a trailing checksum beat that must zero the byte sum.
module wave_ram_loader #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 400
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  s_valid,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_last,
   output logic                  s_ready,
   output logic                  wr_en,
   output logic [ADDR_WIDTH:0]   wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  rd_bank,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   // state  | meaning
   // IDLE   | waiting for start, s_ready low
   // LOAD   | accepting beats, writing into bank wbank
   // COMMIT | last write lands; rd_bank flips with the done pulse on exit
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT} state_t;

`ifdef WAVE_LOADER_CHECKSUM_EN
   localparam logic [ADDR_WIDTH-1:0] END_IDX = ADDR_WIDTH'(DEPTH);
`else
   localparam logic [ADDR_WIDTH-1:0] END_IDX = ADDR_WIDTH'(DEPTH - 1);
`endif

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   idx;
   logic                    wbank;
   logic                    accept;
   logic                    at_end;

   assign s_ready = (state == S_LOAD);
   assign busy    = (state != S_IDLE);
   assign accept  = s_valid & s_ready;
   assign at_end  = (idx == END_IDX);

`ifdef WAVE_LOADER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0]   sum;
   logic [DATA_WIDTH-1:0]   sum_next;
   assign sum_next = sum + s_data;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         idx     <= '0;
         wbank   <= 1'b0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         rd_bank <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
`ifdef WAVE_LOADER_CHECKSUM_EN
         sum     <= '0;
`endif
      end else begin
         wr_en <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  idx   <= '0;
                  wbank <= ~rd_bank;
                  state <= S_LOAD;
`ifdef WAVE_LOADER_CHECKSUM_EN
                  sum   <= '0;
`endif
               end
            end
            S_LOAD: begin
               if (accept) begin
`ifdef WAVE_LOADER_CHECKSUM_EN
                  // the checksum beat sits at idx=DEPTH and is never written to RAM
                  if (!at_end) begin
                     wr_en   <= 1'b1;
                     wr_addr <= {wbank, idx};
                     wr_data <= s_data;
                     sum     <= sum_next;
                  end
                  if (at_end) begin
                     if (s_last && (sum_next == '0)) begin
                        state <= S_COMMIT;
                     end else begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                     end
                  end else if (s_last) begin
                     err   <= 1'b1;
                     state <= S_IDLE;
                  end else begin
                     idx <= idx + 1'b1;
                  end
`else
                  wr_en   <= 1'b1;
                  wr_addr <= {wbank, idx};
                  wr_data <= s_data;
                  if (at_end) begin
                     if (s_last) begin
                        state <= S_COMMIT;
                     end else begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                     end
                  end else if (s_last) begin
                     err   <= 1'b1;
                     state <= S_IDLE;
                  end else begin
                     idx <= idx + 1'b1;
                  end
`endif
               end
            end
            S_COMMIT: begin
               // flip after the final write has landed so the reader never sees a partial table
               rd_bank <= ~rd_bank;
               done    <= 1'b1;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wave_ram_loader.sv
// Self-checking bench for wave_ram_loader: a cycle table for short corner cases plus randomized full loads
// checked against a transaction-level model of the bank/address/data sequence.
module tb_wave_ram_loader;
   localparam int AW    = 9;
   localparam int DW    = 8;
   localparam int DEPTH = 400;
`ifdef WAVE_LOADER_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          s_valid = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          s_last = 1'b0;
   logic          s_ready, wr_en, rd_bank, busy, done, err;
   logic [AW:0]   wr_addr;
   logic [DW-1:0] wr_data;

   int checks = 0;
   int failures = 0;
   logic model_bank = 1'b0;

   always #5 clk = ~clk;

   wave_ram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
      .s_last(s_last), .s_ready(s_ready), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .rd_bank(rd_bank), .busy(busy), .done(done), .err(err)
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic          rst, start, valid;
      logic [DW-1:0] data;
      logic          last;
      logic          ready, wen;
      logic [AW:0]   addr;
      logic [DW-1:0] wdata;
      logic          chk_ad, busy, done, err, bank;
   } vec_t;

   vec_t vecs[12];

   // mode: 0 good, 1 s_last on beat 'at', 2 no s_last on final beat, 3 bad checksum, 4 reset at beat 'at'
   // dsel: 0 random data, 1 data = beat index, 2 constant 0x01
   task automatic do_load(input int duty, input int mode, input int at, input int dsel);
      logic          exp_bank;
      logic [DW-1:0] d, sum;
      int            i, cyc, nbeats, writes;
      bit            v, is_ck, bad;
      exp_bank = ~model_bank;
      nbeats   = CK ? DEPTH + 1 : DEPTH;
      s_valid = 1'b0; s_last = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      chk("load_busy", busy, 1);
      chk("load_ready", s_ready, 1);
      i = 0; cyc = 0; sum = '0; writes = 0;
      while (i < nbeats && cyc < 20000) begin
         cyc++;
         if (mode == 4 && i == at) begin
            rst = 1'b1; s_valid = 1'b0;
            step();
            rst = 1'b0;
            model_bank = 1'b0;
            chk("rst_outs", {s_ready, wr_en, busy, done, err, rd_bank}, 0);
            chk("rst_addr", {wr_addr, wr_data}, 0);
            return;
         end
         v     = (duty >= 100) || ($urandom_range(0, 99) < duty);
         is_ck = CK && (i == DEPTH);
         case (dsel)
            1:       d = i[DW-1:0];
            2:       d = 8'h01;
            default: d = DW'($urandom);
         endcase
         if (is_ck) d = (mode == 3) ? (8'h01 - sum) : (8'h00 - sum);
         s_valid = v;
         s_data  = d;
         s_last  = (mode == 1 && i == at) || (i == nbeats - 1 && mode != 2);
         step();
         if (v) begin
            if (!is_ck) begin
               chk("wr_en", wr_en, 1);
               chk("wr_addr", wr_addr, exp_bank * (1 << AW) + i);
               chk("wr_data", wr_data, d);
               sum = sum + d;
               writes++;
            end else begin
               chk("ck_no_write", wr_en, 0);
            end
            bad = (mode == 1 && i == at) || (mode == 2 && i == nbeats - 1) || (mode == 3 && is_ck);
            if (bad) begin
               chk("err_pulse", {err, done}, 2'b10);
               chk("err_ready", s_ready, 0);
               chk("err_bank", rd_bank, model_bank);
               s_valid = 1'b0; s_last = 1'b0;
               step();
               chk("err_clear", {err, busy, s_ready}, 0);
               chk("err_bank_kept", rd_bank, model_bank);
               return;
            end
            i++;
         end else begin
            chk("gap_no_write", wr_en, 0);
         end
      end
      chk("load_timeout", (cyc < 20000) ? 1 : 0, 1);
      chk("write_count", writes, DEPTH);
      s_valid = 1'b0; s_last = 1'b0;
      chk("commit_state", {busy, done, err, rd_bank}, {1'b1, 1'b0, 1'b0, model_bank});
      step();
      model_bank = ~model_bank;
      chk("done_pulse", {done, err, busy, wr_en}, 4'b1000);
      chk("bank_flip", rd_bank, model_bank);
      step();
      chk("done_clear", {done, err, busy}, 0);
   endtask

   initial begin
      vecs[0]  = '{1,0,0,8'h00,0, 0,0,10'h000,8'h00,1, 0,0,0,0};
      vecs[1]  = '{0,1,0,8'h00,0, 1,0,10'h000,8'h00,0, 1,0,0,0};
      vecs[2]  = '{0,0,1,8'hAA,0, 1,1,10'h200,8'hAA,1, 1,0,0,0};
      vecs[3]  = '{0,0,0,8'h00,0, 1,0,10'h000,8'h00,0, 1,0,0,0};
      vecs[4]  = '{0,0,1,8'h55,1, 0,1,10'h201,8'h55,1, 0,0,1,0};
      vecs[5]  = '{0,0,0,8'h00,0, 0,0,10'h000,8'h00,0, 0,0,0,0};
      vecs[6]  = '{1,1,0,8'h00,0, 0,0,10'h000,8'h00,1, 0,0,0,0};
      vecs[7]  = '{0,0,0,8'h00,0, 0,0,10'h000,8'h00,0, 0,0,0,0};
      vecs[8]  = '{0,1,0,8'h00,0, 1,0,10'h000,8'h00,0, 1,0,0,0};
      vecs[9]  = '{0,1,1,8'h33,0, 1,1,10'h200,8'h33,1, 1,0,0,0};
      vecs[10] = '{0,1,1,8'h44,0, 1,1,10'h201,8'h44,1, 1,0,0,0};
      vecs[11] = '{1,0,0,8'h00,0, 0,0,10'h000,8'h00,1, 0,0,0,0};

      @(negedge clk);
      foreach (vecs[k]) begin
         rst = vecs[k].rst; start = vecs[k].start; s_valid = vecs[k].valid;
         s_data = vecs[k].data; s_last = vecs[k].last;
         step();
         chk($sformatf("vec%0d_ready", k), s_ready, vecs[k].ready);
         chk($sformatf("vec%0d_wr_en", k), wr_en, vecs[k].wen);
         chk($sformatf("vec%0d_flags", k), {busy, done, err, rd_bank},
             {vecs[k].busy, vecs[k].done, vecs[k].err, vecs[k].bank});
         if (vecs[k].chk_ad) chk($sformatf("vec%0d_addr_data", k), {wr_addr, wr_data}, {vecs[k].addr, vecs[k].wdata});
      end
      rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
      model_bank = 1'b0;
      step();

      do_load(100, 0, 0, 1);     // full load into bank 1, data = index
      do_load(100, 0, 0, 0);     // second load goes to bank 0
      do_load(100, 1, 10, 0);    // early s_last
      do_load(50, 0, 0, 0);      // random gaps
      do_load(70, 2, 0, 0);      // final beat without s_last
      do_load(60, 1, 0, 0);      // s_last on the very first beat
      do_load(100, 4, 200, 0);   // reset mid-load
      do_load(100, 0, 0, 0);     // recovery after reset
      if (CK) begin
         do_load(100, 0, 0, 2);  // 400 x 0x01 + checksum 0x70
         do_load(100, 3, 0, 2);  // checksum 0x71 rejected
      end
      do_load(80, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
